// File: rtl/branch_dispatch_if.sv
// Signal bundle between the branch dispatcher and its neighbours: decoder,
// register file/status table, ROB allocator, branch unit and branch station.
interface branch_dispatch_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 6
);
  logic             dec_valid;
  logic             dec_ready;
  logic [OP_W-1:0]  dec_op;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic [XLEN-1:0]  dec_pc;
  logic [XLEN-1:0]  dec_imm;
  logic [4:0]       rf_addr1;
  logic [4:0]       rf_addr2;
  logic [XLEN-1:0]  rf_val1;
  logic [XLEN-1:0]  rf_val2;
  logic [TAG_W-1:0] rf_tag1;
  logic [TAG_W-1:0] rf_tag2;
  logic             rob_alloc_req;
  logic             rob_alloc_ok;
  logic [TAG_W-1:0] rob_alloc_tag;
  logic [TAG_W-1:0] bu_target;
  logic             flush;
  logic [TAG_W-1:0] rs_target;
  logic [XLEN-1:0]  rs_val1;
  logic [XLEN-1:0]  rs_val2;
  logic [TAG_W-1:0] rs_tag1;
  logic [TAG_W-1:0] rs_tag2;
  logic [XLEN-1:0]  rs_pc_addr;
  logic [XLEN-1:0]  rs_offset;
  logic [OP_W-1:0]  rs_op;
  logic             credit_err;

  modport slave (
    input  dec_valid, dec_op, dec_rs1, dec_rs2, dec_pc, dec_imm,
    input  rf_val1, rf_val2, rf_tag1, rf_tag2,
    input  rob_alloc_ok, rob_alloc_tag, bu_target, flush,
    output dec_ready, rf_addr1, rf_addr2, rob_alloc_req,
    output rs_target, rs_val1, rs_val2, rs_tag1, rs_tag2,
    output rs_pc_addr, rs_offset, rs_op, credit_err
  );

  modport master (
    output dec_valid, dec_op, dec_rs1, dec_rs2, dec_pc, dec_imm,
    output rf_val1, rf_val2, rf_tag1, rf_tag2,
    output rob_alloc_ok, rob_alloc_tag, bu_target, flush,
    input  dec_ready, rf_addr1, rf_addr2, rob_alloc_req,
    input  rs_target, rs_val1, rs_val2, rs_tag1, rs_tag2,
    input  rs_pc_addr, rs_offset, rs_op, credit_err
  );
endinterface

// File: rtl/branch_dispatch.sv
// Single-entry branch dispatch buffer: holds one decoded branch, allocates a
// ROB tag, and emits one reservation-station entry, gated by a credit count.
module branch_dispatch #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 4,
  parameter int OP_W     = 6,
  parameter int RS_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  branch_dispatch_if.slave  bus
);
  localparam int               CW          = $clog2(RS_DEPTH + 1);
  localparam logic [TAG_W-1:0] TAG_INVALID = {TAG_W{1'b1}};
  localparam logic [CW-1:0]    CRED_MAX    = CW'(RS_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_STALL} state_t;

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_credits, w_credits_next;
  logic             r_err, w_err_next;
  logic [OP_W-1:0]  r_op;
  logic [4:0]       r_rs1, r_rs2;
  logic [XLEN-1:0]  r_pc, r_imm;

  logic             w_held, w_req, w_dispatch, w_ready, w_accept, w_return, w_full_next;
  logic [XLEN-1:0]  w_val1, w_val2;
  logic [TAG_W-1:0] w_tag1, w_tag2;

  // STALL implies zero credits, so only HELD may request a ROB entry.
  assign w_held     = (r_state != S_IDLE);
  assign w_req      = (r_state == S_HELD) && (r_credits != '0) && !bus.flush;
  assign w_dispatch = w_req && bus.rob_alloc_ok;
  assign w_ready    = (!w_held || w_dispatch) && !bus.flush;
  assign w_accept   = bus.dec_valid && w_ready;
  assign w_return   = (bus.bu_target != TAG_INVALID);

  assign bus.dec_ready     = w_ready;
  assign bus.rob_alloc_req = w_req;
  assign bus.rf_addr1      = r_rs1;
  assign bus.rf_addr2      = r_rs2;
  assign bus.credit_err    = r_err;

  // x0 never has a pending producer and always reads as zero.
  assign w_val1 = (r_rs1 == 5'd0) ? '0 : bus.rf_val1;
  assign w_val2 = (r_rs2 == 5'd0) ? '0 : bus.rf_val2;
  assign w_tag1 = (r_rs1 == 5'd0) ? TAG_INVALID : bus.rf_tag1;
  assign w_tag2 = (r_rs2 == 5'd0) ? TAG_INVALID : bus.rf_tag2;

  always_comb begin
    w_credits_next = r_credits;
    w_err_next     = r_err;
    w_full_next    = w_held;
    w_state_next   = r_state;
    if (w_dispatch && !w_return) begin
      w_credits_next = r_credits - CW'(1);
    end else if (!w_dispatch && w_return) begin
      if (r_credits == CRED_MAX) w_err_next     = 1'b1;
      else                       w_credits_next = r_credits + CW'(1);
    end
    if (bus.flush)       w_full_next = 1'b0;
    else if (w_accept)   w_full_next = 1'b1;
    else if (w_dispatch) w_full_next = 1'b0;
    if (!w_full_next)              w_state_next = S_IDLE;
    else if (w_credits_next == '0) w_state_next = S_STALL;
    else                           w_state_next = S_HELD;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_credits <= CRED_MAX;
      r_err     <= 1'b0;
      r_op      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_pc      <= '0;
      r_imm     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_credits <= w_credits_next;
      r_err     <= w_err_next;
      if (w_accept) begin
        r_op  <= bus.dec_op;
        r_rs1 <= bus.dec_rs1;
        r_rs2 <= bus.dec_rs2;
        r_pc  <= bus.dec_pc;
        r_imm <= bus.dec_imm;
      end
    end
  end

  // Station outputs: a valid target is a one-cycle pulse; payload holds otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.rs_target  <= TAG_INVALID;
      bus.rs_val1    <= '0;
      bus.rs_val2    <= '0;
      bus.rs_tag1    <= '0;
      bus.rs_tag2    <= '0;
      bus.rs_pc_addr <= '0;
      bus.rs_offset  <= '0;
      bus.rs_op      <= '0;
    end else if (w_dispatch) begin
      bus.rs_target  <= bus.rob_alloc_tag;
      bus.rs_val1    <= w_val1;
      bus.rs_val2    <= w_val2;
      bus.rs_tag1    <= w_tag1;
      bus.rs_tag2    <= w_tag2;
      bus.rs_pc_addr <= r_pc;
      bus.rs_offset  <= r_imm;
      bus.rs_op      <= r_op;
    end else begin
      bus.rs_target  <= TAG_INVALID;
    end
  end
endmodule
